// File: rtl/skinny_sbox8_seq_ctrl.sv
// Sequencer driving one external masked SKINNY sbox8 over the 16 bytes
// of a two-share 128-bit state, one fresh refresh mask per byte.
module skinny_sbox8_seq_ctrl #(
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] st0_i,
  input  logic [127:0] st1_i,
  output logic         busy,
  output logic         done,
  output logic [127:0] st0_o,
  output logic [127:0] st1_o,
  input  logic [7:0]   rnd_i,
  input  logic         rnd_valid_i,
  output logic         rnd_ready_o,
  output logic [7:0]   sb_si0,
  output logic [7:0]   sb_si1,
  output logic [7:0]   sb_r,
  input  logic [7:0]   sb_bo0,
  input  logic [7:0]   sb_bo1
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    CAPT,
    DONE
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

  state_t       state_q;
  logic [127:0] st0_q;
  logic [127:0] st1_q;
  logic [3:0]   idx_q;
  logic [2:0]   cnt_q;
  logic [7:0]   r_q;
  logic         busy_q;
  logic         done_q;
  logic         act;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st0_q   <= '0;
      st1_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            st0_q   <= st0_i;
            st1_q   <= st1_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (rnd_valid_i) begin
            r_q     <= rnd_i;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == CNT_LAST)
            state_q <= CAPT;
        end
        CAPT: begin
          // share 0 and share 1 are written independently, never merged
          st0_q[{idx_q, 3'b000} +: 8] <= sb_bo0;
          st1_q[{idx_q, 3'b000} +: 8] <= sb_bo1;
          if (idx_q == 4'd15) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= FETCH;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign act = (state_q == FETCH) ||
               (state_q == HOLD) ||
               (state_q == CAPT);

  always_comb begin
    sb_si0 = '0;
    sb_si1 = '0;
    sb_r   = '0;
    if (act) begin
      sb_si0 = st0_q[{idx_q, 3'b000} +: 8];
      sb_si1 = st1_q[{idx_q, 3'b000} +: 8];
      sb_r   = r_q;
    end
  end

  assign rnd_ready_o = (state_q == FETCH);
  assign busy        = busy_q;
  assign done        = done_q;
  assign st0_o       = st0_q;
  assign st1_o       = st1_q;

endmodule

// File: tb/tb_skinny_sbox8_seq_ctrl.sv
// Directed bench: behavioural masked sbox stub with LAT-cycle settle,
// randomness source with stall injection, and result/timing checks.
module tb_skinny_sbox8_seq_ctrl;

  localparam int LAT = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] st0_i;
  logic [127:0] st1_i;
  logic         busy;
  logic         done;
  logic [127:0] st0_o;
  logic [127:0] st1_o;
  logic [7:0]   rnd_i;
  logic         rnd_valid_i;
  logic         rnd_ready_o;
  logic [7:0]   sb_si0;
  logic [7:0]   sb_si1;
  logic [7:0]   sb_r;
  logic [7:0]   sb_bo0;
  logic [7:0]   sb_bo1;

  int n_tests = 0;
  int n_fail  = 0;
  int stab    = 0;
  int hs      = 0;
  int stall   = 0;
  bit mon_en  = 0;

  skinny_sbox8_seq_ctrl #(.LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .st0_i       (st0_i),
    .st1_i       (st1_i),
    .busy        (busy),
    .done        (done),
    .st0_o       (st0_o),
    .st1_o       (st1_o),
    .rnd_i       (rnd_i),
    .rnd_valid_i (rnd_valid_i),
    .rnd_ready_o (rnd_ready_o),
    .sb_si0      (sb_si0),
    .sb_si1      (sb_si1),
    .sb_r        (sb_r),
    .sb_bo0      (sb_bo0),
    .sb_bo1      (sb_bo1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Known SKINNY sbox8 points; other inputs are not used by the vectors.
  function automatic logic [7:0] sref(input logic [7:0] u);
    case (u)
      8'h00: sref = 8'h65;
      8'h01: sref = 8'h4c;
      8'h02: sref = 8'h6a;
      8'h03: sref = 8'h42;
      8'h04: sref = 8'h4b;
      8'h05: sref = 8'h63;
      8'h06: sref = 8'h43;
      8'h07: sref = 8'h6b;
      8'h08: sref = 8'h55;
      8'h09: sref = 8'h75;
      8'h0a: sref = 8'h5a;
      8'h0b: sref = 8'h7a;
      8'h0c: sref = 8'h53;
      8'h0d: sref = 8'h73;
      8'h0e: sref = 8'h5b;
      8'h0f: sref = 8'h7b;
      8'hff: sref = 8'hff;
      default: sref = u;
    endcase
  endfunction

  // Output is only correct once inputs have been held LAT cycles.
  assign sb_bo0 = (stab >= LAT) ? (sref(sb_si0 ^ sb_si1) ^ sb_r) : 8'ha5;
  assign sb_bo1 = (stab >= LAT) ? sb_r : 8'h00;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [23:0] cur;
    logic [23:0] prev;
    bit pbusy;
    bit pready;
    prev = '0;
    pbusy = 0;
    pready = 0;
    rnd_valid_i = 1;
    rnd_i = '0;
    forever begin
      @(negedge clk);
      cur = {sb_si0, sb_si1, sb_r};
      if (mon_en) begin
        if (!busy)
          chk("sb_idle", 128'(cur), 128'd0);
        else if (!rnd_ready_o && pbusy && !pready)
          chk("sb_hold", 128'(cur), 128'(prev));
      end
      stab = (cur == prev) ? stab + 1 : 0;
      prev = cur;
      pbusy = busy;
      pready = rnd_ready_o;
      rnd_i = 8'($urandom);
      if (rnd_ready_o && hs == 3 && stall > 0) begin
        rnd_valid_i = 0;
        stall--;
      end else begin
        rnd_valid_i = 1;
      end
      if (rnd_ready_o && rnd_valid_i)
        hs++;
    end
  end

  task automatic run(input logic [127:0] a, input logic [127:0] b,
                     output int cyc, output logic [127:0] o0,
                     output logic [127:0] o1);
    @(negedge clk);
    st0_i = a;
    st1_i = b;
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (!done)
      chk("timeout", 128'd0, 128'd1);
    o0 = st0_o;
    o1 = st1_o;
    chk("busy_at_done", 128'(busy), 128'd0);
    @(negedge clk);
    chk("done_pulse", 128'(done), 128'd0);
  endtask

  localparam logic [127:0] CNTU = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CNTS = 128'h7b5b73537a5a75556b43634b426a4c65;

  initial begin
    int cyc;
    int ndone;
    logic [127:0] r;
    logic [127:0] o0;
    logic [127:0] o1;
    logic [127:0] p0;
    rst = 1;
    start = 0;
    st0_i = '0;
    st1_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ready", 128'(rnd_ready_o), 128'd0);
    chk("rst_st0", st0_o, 128'd0);
    chk("rst_st1", st1_o, 128'd0);
    chk("rst_sb", 128'({sb_si0, sb_si1, sb_r}), 128'd0);
    rst = 0;
    mon_en = 1;

    r = {$urandom, $urandom, $urandom, $urandom};
    hs = 0;
    run(r, r, cyc, o0, o1);
    chk("zero_cyc", 128'(cyc), 128'd97);
    chk("zero_res", o0 ^ o1, {16{8'h65}});
    chk("zero_hs", 128'(hs), 128'd16);

    r = {$urandom, $urandom, $urandom, $urandom};
    run(r, ~r, cyc, o0, o1);
    chk("ff_cyc", 128'(cyc), 128'd97);
    chk("ff_res", o0 ^ o1, {16{8'hff}});
    p0 = o0;
    run(r, ~r, cyc, o0, o1);
    chk("ff_res2", o0 ^ o1, {16{8'hff}});
    chk("ff_fresh", 128'(o0 != p0), 128'd1);

    r = {$urandom, $urandom, $urandom, $urandom};
    run(r, r ^ CNTU, cyc, o0, o1);
    chk("cnt_res", o0 ^ o1, CNTS);

    r = {$urandom, $urandom, $urandom, $urandom};
    hs = 0;
    stall = 10;
    run(r, r, cyc, o0, o1);
    chk("stall_cyc", 128'(cyc), 128'd107);
    chk("stall_res", o0 ^ o1, {16{8'h65}});
    chk("stall_hs", 128'(hs), 128'd16);

    @(negedge clk);
    st0_i = r;
    st1_i = ~r;
    start = 1;
    @(negedge clk);
    start = 0;
    ndone = 0;
    for (int i = 1; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_busy", 128'(busy), 128'd0);
    chk("mid_done", 128'(done + ndone), 128'd0);
    chk("mid_st0", st0_o, 128'd0);
    chk("mid_st1", st1_o, 128'd0);
    chk("mid_ready", 128'(rnd_ready_o), 128'd0);
    run(r, r, cyc, o0, o1);
    chk("post_cyc", 128'(cyc), 128'd97);
    chk("post_res", o0 ^ o1, {16{8'h65}});

    r = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    st0_i = r;
    st1_i = r ^ CNTU;
    start = 1;
    @(negedge clk);
    st0_i = ~r;
    st1_i = r;
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_cyc", 128'(cyc), 128'd97);
    chk("ign_res", st0_o ^ st1_o, CNTS);
    @(negedge clk);
    start = 0;
    ndone = 0;
    chk("ign_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 120; i++) begin
      if (done) ndone++;
      if (busy) ndone++;
      @(negedge clk);
    end
    chk("ign_once", 128'(ndone), 128'd0);
    chk("ign_hold", st0_o ^ st1_o, CNTS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
